usr_irq_hub: RTL and testbench
==============================

USR_IRQ_HUB -- requirements
Module: usr_irq_hub

Interface
REQ-001 The block SHALL have parameter C_CH_NUM, default 3, number of interrupt channels (1..16).
REQ-002 The block SHALL have parameter C_CNT_W, default 8, width of each per-channel pending-event counter (2..16).
REQ-003 The block SHALL have parameter C_TIMEOUT, default 0, cycles to wait for ack before abandoning a request (0 = never time out).
REQ-004 clk  in  1  single clock for all logic (PCIe user clock domain).
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 irq_evt  in  C_CH_NUM  per-channel one-cycle event pulse.
REQ-007 irq_mask  in  C_CH_NUM  1 = events on that channel are discarded.
REQ-008 ctrl_wr  in  1  one-cycle command strobe from the register block.
REQ-009 ctrl_ch  in  4  channel index of the command.
REQ-010 ctrl_cmd  in  2  command: 0 NOP, 1 CLEAR, 2 ARM, 3 NOP.
REQ-011 usr_irq_ack  in  C_CH_NUM  per-bit ack pulse from the PCIe DMA core.
REQ-012 usr_irq_req  out  C_CH_NUM  per-bit interrupt request to the PCIe DMA core.
REQ-013 irq_pend  out  C_CH_NUM  1 while the channel state is not IDLE.
REQ-014 pend_cnt  out  C_CH_NUM*C_CNT_W  per-channel event count, channel i at bits [i*C_CNT_W +: C_CNT_W].
REQ-015 cnt_ovf  out  C_CH_NUM  sticky flag: counter saturated.
REQ-016 to_err  out  C_CH_NUM  sticky flag: request timed out.

Function
REQ-017 Each channel SHALL run an independent FSM with states IDLE, PEND, REQ and SERV.
REQ-018 An effective event SHALL be irq_evt[i] & ~irq_mask[i]; masked events SHALL have no effect.
REQ-019 An effective event SHALL increment pend_cnt[i] in every state, saturating at 2^C_CNT_W-1; an event arriving at saturation SHALL set cnt_ovf[i].
REQ-020 A command SHALL apply only when ctrl_wr=1 and ctrl_ch < C_CH_NUM; any other ctrl_ch SHALL be ignored.
REQ-021 IDLE -> PEND SHALL occur on an effective event; ARM in IDLE SHALL be ignored.
REQ-022 PEND -> REQ SHALL occur on ARM; usr_irq_req[i] SHALL be 1 from the next cycle.
REQ-023 In REQ, usr_irq_ack[i]=1 SHALL cause REQ -> SERV, and usr_irq_req[i] SHALL be 0 from the next cycle.
REQ-024 usr_irq_ack[i] SHALL be ignored in any state other than REQ.
REQ-025 If C_TIMEOUT>0, the block SHALL count cycles in REQ. When the count reaches C_TIMEOUT without an ack, the FSM SHALL go REQ -> PEND, deassert the request and set to_err[i]. The count SHALL restart on every entry to REQ.
REQ-026 CLEAR in any state SHALL deassert the request. If an effective event is coincident, CLEAR SHALL set pend_cnt[i]=1 and state PEND; otherwise it SHALL set pend_cnt[i]=0 and state IDLE.
REQ-027 CLEAR SHALL also clear cnt_ovf[i] and to_err[i].
REQ-028 An ack coincident with CLEAR SHALL be overridden by CLEAR; an ack coincident with the timeout SHALL take priority (REQ -> SERV, no to_err).
REQ-029 ARM in REQ or SERV SHALL be ignored.
REQ-030 usr_irq_req[i] SHALL be a registered output equal to (state==REQ), with no combinational path from any input.

Reset
REQ-031 While rst_n=0 at a rising clk edge, all FSMs SHALL go to IDLE, and usr_irq_req, irq_pend, pend_cnt, cnt_ovf, to_err and the timeout counters SHALL be 0.
REQ-032 Reset asserted mid-request SHALL drop usr_irq_req on the next edge; any ack arriving during or after reset SHALL be ignored.

Verification
REQ-033 C_CH_NUM=3, C_TIMEOUT=0. Stimulus: 2 events on ch1, ARM ch1, ack pulse, CLEAR ch1. Required: pend_cnt ch1=2, req[1] high 1 cycle after ARM and low 1 cycle after ack, state IDLE and cnt=0 after CLEAR.
REQ-034 C_TIMEOUT=16. Stimulus: event ch0, ARM, no ack. Required: req[0] high exactly 16 cycles, then PEND and to_err[0]=1; a second ARM reasserts req[0].
REQ-035 C_CNT_W=2. Stimulus: 5 events ch2. Required: pend_cnt=3 and cnt_ovf[2]=1; then CLEAR coincident with an event gives cnt=1, state PEND and ovf=0.
REQ-036 Stimulus: irq_mask=3'b010 with events on all channels; then ctrl_ch=7 ARM; then ack while ch0 is in PEND. Required: ch1 stays IDLE with cnt 0; the ch7 command has no effect; the ack is ignored.
REQ-037 Stimulus: all 3 channels in REQ with simultaneous acks on ch0/ch2 and CLEAR on ch1. Required: ch0 and ch2 go to SERV, ch1 goes to IDLE, and all requests are low the next cycle.
REQ-038 Stimulus: rst_n=0 for 1 cycle while ch0 is in REQ. Required: all outputs are 0 on the next edge.

Source files
------------

// File: rtl/usr_irq_hub_if.sv
// rtl/usr_irq_hub_if.sv - signal bundle between the register/DMA side and usr_irq_hub
//
// Signals (C_CH_NUM channels, C_CNT_W-bit counters):
//   irq_evt, irq_mask    event pulses and per-channel discard mask
//   ctrl_wr/ctrl_ch/ctrl_cmd  one-cycle command strobe, channel index, opcode
//   usr_irq_ack          per-channel ack from the PCIe DMA core
//   usr_irq_req          per-channel interrupt request to the PCIe DMA core
//   irq_pend, pend_cnt, cnt_ovf, to_err  status back to the register block
// master: the side that drives events/commands/acks; slave: the hub.
interface usr_irq_hub_if #(
    parameter int C_CH_NUM = 3,
    parameter int C_CNT_W  = 8
) ();
    logic [C_CH_NUM-1:0]         irq_evt;
    logic [C_CH_NUM-1:0]         irq_mask;
    logic                        ctrl_wr;
    logic [3:0]                  ctrl_ch;
    logic [1:0]                  ctrl_cmd;
    logic [C_CH_NUM-1:0]         usr_irq_ack;
    logic [C_CH_NUM-1:0]         usr_irq_req;
    logic [C_CH_NUM-1:0]         irq_pend;
    logic [C_CH_NUM*C_CNT_W-1:0] pend_cnt;
    logic [C_CH_NUM-1:0]         cnt_ovf;
    logic [C_CH_NUM-1:0]         to_err;

    modport master (
        output irq_evt, irq_mask, ctrl_wr, ctrl_ch, ctrl_cmd, usr_irq_ack,
        input  usr_irq_req, irq_pend, pend_cnt, cnt_ovf, to_err
    );

    modport slave (
        input  irq_evt, irq_mask, ctrl_wr, ctrl_ch, ctrl_cmd, usr_irq_ack,
        output usr_irq_req, irq_pend, pend_cnt, cnt_ovf, to_err
    );
endinterface

// File: rtl/usr_irq_hub.sv
// rtl/usr_irq_hub.sv - per-channel user interrupt request hub for the PCIe DMA core
//
// Ports:
//   clk      single clock (PCIe user clock domain)
//   rst_n    synchronous active-low reset
//   irq_bus  usr_irq_hub_if.slave: events, mask, commands, acks in;
//            requests, pending flags, event counters, sticky flags out
// Each channel runs IDLE -> PEND -> (ARM) REQ -> (ack) SERV, with CLEAR
// returning it to IDLE (or PEND when an event lands in the same cycle).
module usr_irq_hub #(
    parameter int C_CH_NUM  = 3,
    parameter int C_CNT_W   = 8,
    parameter int C_TIMEOUT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    usr_irq_hub_if.slave irq_bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PEND = 2'd1;
    localparam logic [1:0] S_REQ  = 2'd2;
    localparam logic [1:0] S_SERV = 2'd3;

    // Cycles-in-REQ counter runs 0..C_TIMEOUT-1, so the request is held for
    // exactly C_TIMEOUT cycles before it is abandoned.
    localparam int                 C_TW      = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT) : 1;
    localparam logic [C_TW-1:0]    C_TO_LAST = C_TW'((C_TIMEOUT > 0) ? C_TIMEOUT - 1 : 0);
    localparam logic [C_CNT_W-1:0] C_CNT_MAX = '1;

    logic [1:0]                  r_state  [C_CH_NUM];
    logic [1:0]                  w_nxt    [C_CH_NUM];
    logic [C_CNT_W-1:0]          r_cnt    [C_CH_NUM];
    logic [C_TW-1:0]             r_to_cnt [C_CH_NUM];
    logic [C_CH_NUM-1:0]         r_ovf;
    logic [C_CH_NUM-1:0]         r_err;
    logic [C_CH_NUM-1:0]         w_evt;
    logic [C_CH_NUM-1:0]         w_clr;
    logic [C_CH_NUM-1:0]         w_arm;
    logic [C_CH_NUM-1:0]         w_tmo;
    logic [C_CH_NUM-1:0]         w_req;
    logic [C_CH_NUM-1:0]         w_pend;
    logic [C_CH_NUM*C_CNT_W-1:0] w_cnt_flat;

    // Event qualification and command decode; out-of-range channel indices
    // decode to no channel at all.
    always_comb begin
        w_evt = irq_bus.irq_evt & ~irq_bus.irq_mask;
        w_clr = '0;
        w_arm = '0;
        w_tmo = '0;
        for (int i = 0; i < C_CH_NUM; i++) begin
            if (irq_bus.ctrl_wr && (32'(irq_bus.ctrl_ch) < C_CH_NUM) &&
                (32'(irq_bus.ctrl_ch) == i)) begin
                w_clr[i] = (irq_bus.ctrl_cmd == 2'd1);
                w_arm[i] = (irq_bus.ctrl_cmd == 2'd2);
            end
            w_tmo[i] = (C_TIMEOUT > 0) && (r_state[i] == S_REQ) && (r_to_cnt[i] == C_TO_LAST);
        end
    end

    // Next state: CLEAR overrides everything, an ack beats a same-cycle timeout.
    always_comb begin
        for (int i = 0; i < C_CH_NUM; i++) begin
            w_nxt[i] = r_state[i];
            if (w_clr[i]) begin
                w_nxt[i] = w_evt[i] ? S_PEND : S_IDLE;
            end else begin
                case (r_state[i])
                    S_IDLE:  if (w_evt[i]) w_nxt[i] = S_PEND;
                    S_PEND:  if (w_arm[i]) w_nxt[i] = S_REQ;
                    S_REQ: begin
                        if (irq_bus.usr_irq_ack[i]) w_nxt[i] = S_SERV;
                        else if (w_tmo[i])          w_nxt[i] = S_PEND;
                    end
                    default: w_nxt[i] = r_state[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < C_CH_NUM; i++) begin
            if (!rst_n) r_state[i] <= S_IDLE;
            else        r_state[i] <= w_nxt[i];
        end
    end

    // Event counters, sticky flags and the REQ dwell counter. The dwell
    // counter is zero outside REQ, so every entry to REQ restarts it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < C_CH_NUM; i++) begin
                r_cnt[i]    <= '0;
                r_to_cnt[i] <= '0;
            end
            r_ovf <= '0;
            r_err <= '0;
        end else begin
            for (int i = 0; i < C_CH_NUM; i++) begin
                r_to_cnt[i] <= ((r_state[i] == S_REQ) && (w_nxt[i] == S_REQ)) ?
                               r_to_cnt[i] + 1'b1 : '0;
                if (w_clr[i]) begin
                    r_cnt[i] <= {{(C_CNT_W-1){1'b0}}, w_evt[i]};
                    r_ovf[i] <= 1'b0;
                    r_err[i] <= 1'b0;
                end else begin
                    if (w_evt[i]) begin
                        if (r_cnt[i] == C_CNT_MAX) r_ovf[i] <= 1'b1;
                        else                       r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                    if (w_tmo[i] && !irq_bus.usr_irq_ack[i]) r_err[i] <= 1'b1;
                end
            end
        end
    end

    // Outputs decode registered state only; no input reaches them combinationally.
    always_comb begin
        w_req      = '0;
        w_pend     = '0;
        w_cnt_flat = '0;
        for (int i = 0; i < C_CH_NUM; i++) begin
            w_req[i]                         = (r_state[i] == S_REQ);
            w_pend[i]                        = (r_state[i] != S_IDLE);
            w_cnt_flat[i*C_CNT_W +: C_CNT_W] = r_cnt[i];
        end
    end

    assign irq_bus.usr_irq_req = w_req;
    assign irq_bus.irq_pend    = w_pend;
    assign irq_bus.pend_cnt    = w_cnt_flat;
    assign irq_bus.cnt_ovf     = r_ovf;
    assign irq_bus.to_err      = r_err;
endmodule

// File: tb/tb_usr_irq_hub.sv
// tb/tb_usr_irq_hub.sv - scoreboard bench for usr_irq_hub, two configurations side by side
module tb_usr_irq_hub;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // dut0: 8-bit counters, no timeout. dut1: 2-bit counters, 16-cycle timeout.
    usr_irq_hub_if #(.C_CH_NUM(3), .C_CNT_W(8)) if0 ();
    usr_irq_hub_if #(.C_CH_NUM(3), .C_CNT_W(2)) if1 ();

    usr_irq_hub #(.C_CH_NUM(3), .C_CNT_W(8), .C_TIMEOUT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .irq_bus(if0.slave));
    usr_irq_hub #(.C_CH_NUM(3), .C_CNT_W(2), .C_TIMEOUT(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .irq_bus(if1.slave));

    typedef struct packed {
        logic [2:0]      req;
        logic [2:0]      pend;
        logic [2:0]      ovf;
        logic [2:0]      err;
        logic [2:0][7:0] cnt;
    } snap_t;

    snap_t q0[$];
    snap_t q1[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;

    // Reference model: channel phases by name, REQ dwell as a 1-based age.
    localparam int IDLE = 0, PEND = 1, REQ = 2, SERV = 3;
    int p_cw [2] = '{8, 2};
    int p_to [2] = '{0, 16};
    int m_st [2][3];
    int m_cnt[2][3];
    int m_age[2][3];
    bit m_ovf[2][3];
    bit m_err[2][3];

    function automatic void model_step(input bit rst, input bit [2:0] evt, input bit [2:0] mask,
                                       input bit wr, input bit [3:0] ch, input bit [1:0] cmd,
                                       input bit [2:0] ack);
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 3; c++) begin
                bit e, clr, arm, a;
                int mx;
                e   = evt[c] && !mask[c];
                clr = wr && (int'(ch) == c) && (cmd == 2'd1);
                arm = wr && (int'(ch) == c) && (cmd == 2'd2);
                a   = ack[c];
                mx  = (1 << p_cw[d]) - 1;
                if (!rst) begin
                    m_st[d][c] = IDLE; m_cnt[d][c] = 0; m_age[d][c] = 0;
                    m_ovf[d][c] = 0;   m_err[d][c] = 0;
                end else if (clr) begin
                    m_cnt[d][c] = e ? 1 : 0;
                    m_ovf[d][c] = 0;
                    m_err[d][c] = 0;
                    m_st[d][c]  = e ? PEND : IDLE;
                    m_age[d][c] = 0;
                end else begin
                    if (e) begin
                        if (m_cnt[d][c] == mx) m_ovf[d][c] = 1;
                        else                   m_cnt[d][c]++;
                    end
                    if (m_st[d][c] == IDLE) begin
                        if (e) m_st[d][c] = PEND;
                    end else if (m_st[d][c] == PEND) begin
                        if (arm) begin m_st[d][c] = REQ; m_age[d][c] = 1; end
                    end else if (m_st[d][c] == REQ) begin
                        if (a) begin
                            m_st[d][c] = SERV; m_age[d][c] = 0;
                        end else if (p_to[d] > 0 && m_age[d][c] >= p_to[d]) begin
                            m_st[d][c] = PEND; m_age[d][c] = 0; m_err[d][c] = 1;
                        end else begin
                            m_age[d][c]++;
                        end
                    end
                end
            end
        end
    endfunction

    function automatic snap_t model_snap(input int d);
        snap_t s;
        s = '0;
        for (int c = 0; c < 3; c++) begin
            s.req[c]  = (m_st[d][c] == REQ);
            s.pend[c] = (m_st[d][c] != IDLE);
            s.ovf[c]  = m_ovf[d][c];
            s.err[c]  = m_err[d][c];
            s.cnt[c]  = 8'(m_cnt[d][c]);
        end
        return s;
    endfunction

    // Drives one cycle of stimulus at the falling edge and queues the response
    // expected after the following rising edge.
    task automatic step(input bit rst, input bit [2:0] evt, input bit [2:0] mask, input bit wr,
                        input bit [3:0] ch, input bit [1:0] cmd, input bit [2:0] ack);
        @(negedge clk);
        rst_n           = rst;
        if0.irq_evt     = evt;  if1.irq_evt     = evt;
        if0.irq_mask    = mask; if1.irq_mask    = mask;
        if0.ctrl_wr     = wr;   if1.ctrl_wr     = wr;
        if0.ctrl_ch     = ch;   if1.ctrl_ch     = ch;
        if0.ctrl_cmd    = cmd;  if1.ctrl_cmd    = cmd;
        if0.usr_irq_ack = ack;  if1.usr_irq_ack = ack;
        model_step(rst, evt, mask, wr, ch, cmd, ack);
        q0.push_back(model_snap(0));
        q1.push_back(model_snap(1));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1, 3'b000, 3'b000, 0, 4'd0, 2'd0, 3'b000);
    endtask
    task automatic ev(input bit [2:0] e);
        step(1, e, 3'b000, 0, 4'd0, 2'd0, 3'b000);
    endtask
    task automatic cmd(input bit [3:0] ch, input bit [1:0] c);
        step(1, 3'b000, 3'b000, 1, ch, c, 3'b000);
    endtask
    task automatic clear_all();
        cmd(4'd0, 2'd1); cmd(4'd1, 2'd1); cmd(4'd2, 2'd1);
    endtask

    task automatic cmp(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, d, cyc, act, exp);
        end
    endtask

    task automatic cmp_snap(input int d, input snap_t a, input snap_t e);
        cmp("usr_irq_req", d, 32'(a.req),  32'(e.req));
        cmp("irq_pend",    d, 32'(a.pend), 32'(e.pend));
        cmp("cnt_ovf",     d, 32'(a.ovf),  32'(e.ovf));
        cmp("to_err",      d, 32'(a.err),  32'(e.err));
        for (int c = 0; c < 3; c++) cmp($sformatf("pend_cnt[%0d]", c), d, 32'(a.cnt[c]), 32'(e.cnt[c]));
    endtask

    // Monitor: samples both DUTs just after each rising edge.
    initial begin
        snap_t a0, a1, e0, e1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q0.size() > 0 && q1.size() > 0) begin
                e0 = q0.pop_front();
                e1 = q1.pop_front();
                a0 = '0;
                a1 = '0;
                a0.req = if0.usr_irq_req; a0.pend = if0.irq_pend;
                a0.ovf = if0.cnt_ovf;     a0.err  = if0.to_err;
                a1.req = if1.usr_irq_req; a1.pend = if1.irq_pend;
                a1.ovf = if1.cnt_ovf;     a1.err  = if1.to_err;
                for (int c = 0; c < 3; c++) begin
                    a0.cnt[c] = if0.pend_cnt[c*8 +: 8];
                    a1.cnt[c] = {6'b0, if1.pend_cnt[c*2 +: 2]};
                end
                cmp_snap(0, a0, e0);
                cmp_snap(1, a1, e1);
            end
        end
    end

    initial begin
        if0.irq_evt = '0; if0.irq_mask = '0; if0.ctrl_wr = 0; if0.ctrl_ch = '0;
        if0.ctrl_cmd = '0; if0.usr_irq_ack = '0;
        if1.irq_evt = '0; if1.irq_mask = '0; if1.ctrl_wr = 0; if1.ctrl_ch = '0;
        if1.ctrl_cmd = '0; if1.usr_irq_ack = '0;

        step(0, 3'b000, 3'b000, 0, 4'd0, 2'd0, 3'b000);
        step(0, 3'b111, 3'b000, 0, 4'd0, 2'd0, 3'b111);

        // Basic flow on ch1: two events, ARM, ack, CLEAR.
        ev(3'b010); ev(3'b010);
        cmd(4'd1, 2'd2); idle(2);
        step(1, 3'b000, 3'b000, 0, 4'd0, 2'd0, 3'b010); idle(2);
        cmd(4'd1, 2'd1); idle(2);

        // Timeout on ch0 (dut1), then re-ARM; dut0 ignores the second ARM in REQ.
        ev(3'b001); cmd(4'd0, 2'd2); idle(20);
        cmd(4'd0, 2'd2); idle(3);
        step(1, 3'b000, 3'b000, 0, 4'd0, 2'd0, 3'b001); idle(2);
        clear_all();

        // Counter saturation on ch2, then CLEAR with a coincident event.
        for (int k = 0; k < 5; k++) ev(3'b100);
        step(1, 3'b100, 3'b000, 1, 4'd2, 2'd1, 3'b000); idle(2);
        clear_all();

        // Masking, out-of-range channel commands, ack outside REQ.
        step(1, 3'b111, 3'b010, 0, 4'd0, 2'd0, 3'b000);
        step(1, 3'b000, 3'b010, 1, 4'd7, 2'd2, 3'b000);
        step(1, 3'b000, 3'b010, 1, 4'd7, 2'd1, 3'b000);
        step(1, 3'b000, 3'b010, 0, 4'd0, 2'd0, 3'b001); idle(2);
        clear_all();

        // All channels in REQ: acks on ch0/ch2 with CLEAR on ch1.
        ev(3'b111);
        cmd(4'd0, 2'd2); cmd(4'd1, 2'd2); cmd(4'd2, 2'd2);
        step(1, 3'b000, 3'b000, 1, 4'd1, 2'd1, 3'b101); idle(2);
        clear_all();

        // Reset while ch0 requests, with acks during and after reset.
        ev(3'b001); cmd(4'd0, 2'd2); idle(1);
        step(0, 3'b000, 3'b000, 0, 4'd0, 2'd0, 3'b001);
        step(1, 3'b000, 3'b000, 0, 4'd0, 2'd0, 3'b001); idle(2);

        // Randomized traffic.
        for (int k = 0; k < 800; k++) begin
            bit [2:0] e, m, a;
            for (int c = 0; c < 3; c++) begin
                e[c] = ($urandom_range(0, 3) == 0);
                m[c] = ($urandom_range(0, 5) == 0);
                a[c] = ($urandom_range(0, 23) == 0);
            end
            step(($urandom_range(0, 299) != 0), e, m, ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), a);
        end
        idle(2);

        @(posedge clk);
        #3;
        n_tests++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d/%0d entries left expected 0", q0.size(), q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
